mul_norm: RTL

- Normalisation stage of the mul_para datapath. It sits directly downstream of the leading-one detector.
- Consumes the product mantissa and exponent together with the detector's leading-zero count.
- Left-shifts the mantissa so its MSB is 1 and adjusts the exponent to match. Clamps the shift when the exponent would drop into the subnormal range.
- Two-stage valid/ready pipeline with full-throughput backpressure; feeds the rounding stage.

---
 rtl/mul_pkg.sv | 19 +
 rtl/mul_norm_shl.sv | 22 ++
 rtl/mul_norm.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and default widths for the mul_para datapath.
// norm_op_t carries the stage-1 decision of the normaliser into its shift stage.
package mul_pkg;

  localparam int MAN_W_DEF = 24;
  localparam int EXP_W_DEF = 10;
  localparam int LZC_W_DEF = $clog2(MAN_W_DEF);

  typedef struct packed {
    logic [MAN_W_DEF-1:0] man;
    logic [EXP_W_DEF-1:0] exp;
    logic [LZC_W_DEF-1:0] shift;
    logic                 sticky;
    logic                 zero;
    logic                 denorm;
    logic                 tiny;
  } norm_op_t;

endpackage

// File: rtl/mul_norm_shl.sv
// Combinational left barrel shifter: one 2:1 mux rank per shift-amount bit.
// Zeros enter from the LSB side.
module mul_norm_shl #(
  parameter int MAN_W = 24,
  parameter int SH_W  = $clog2(MAN_W)
) (
  input  logic [MAN_W-1:0] i_data,
  input  logic [SH_W-1:0]  i_shift,
  output logic [MAN_W-1:0] o_data
);

  logic [MAN_W-1:0] w_stage [SH_W+1];

  assign w_stage[0] = i_data;

  for (genvar gi = 0; gi < SH_W; gi++) begin : g_rank
    assign w_stage[gi+1] = i_shift[gi] ? (w_stage[gi] << (2 ** gi)) : w_stage[gi];
  end

  assign o_data = w_stage[SH_W];

endmodule

// File: rtl/mul_norm.sv
// Normalisation stage: stage 1 picks shift/exponent from the leading-zero count,
// stage 2 applies the shift. Two-deep valid/ready pipeline, one beat per cycle.
module mul_norm
  import mul_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int LZC_W = $clog2(MAN_W),
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] in_man,
  input  logic [LZC_W-1:0] in_lzc,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] out_man,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sticky,
  output logic             out_zero,
  output logic             out_denorm,
  output logic             out_tiny
);

  // The stage-1 register type is sized from the package defaults.
  if (MAN_W != MAN_W_DEF || EXP_W != EXP_W_DEF || LZC_W != LZC_W_DEF) begin : g_param_check
    $error("mul_norm: widths must match mul_pkg defaults");
  end

  localparam logic [LZC_W-1:0] LZC_MAX = LZC_W'(MAN_W - 1);

  logic                    w_s1_adv;
  logic                    w_s2_adv;
  logic                    w_zero;
  logic                    w_tiny;
  logic                    w_gt;
  logic [LZC_W-1:0]        w_lzc_c;
  logic signed [EXP_W:0]   w_exp_x;
  logic signed [EXP_W:0]   w_lzc_x;
  logic signed [EXP_W:0]   w_exp_diff;
  logic signed [EXP_W:0]   w_exp_m1;
  logic                    w_unused;
  norm_op_t                w_op;
  logic [MAN_W-1:0]        w_shl_man;

  logic                    r_s1_valid;
  norm_op_t                r_s1;
  logic                    r_s2_valid;
  logic [MAN_W-1:0]        r_man;
  logic [EXP_W-1:0]        r_exp;
  logic                    r_sticky;
  logic                    r_zero;
  logic                    r_denorm;
  logic                    r_tiny;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // The detector reports an out-of-range count for all-zero input; clamp it.
  assign w_zero     = (in_man == '0);
  assign w_lzc_c    = (in_lzc > LZC_MAX) ? LZC_MAX : in_lzc;
  assign w_exp_x    = {in_exp[EXP_W-1], in_exp};
  assign w_lzc_x    = {{(EXP_W + 1 - LZC_W){1'b0}}, w_lzc_c};
  assign w_tiny     = w_exp_x[EXP_W] || (w_exp_x == '0);
  assign w_gt       = (w_exp_x > w_lzc_x);
  assign w_exp_diff = w_exp_x - w_lzc_x;
  assign w_exp_m1   = w_exp_x - {{EXP_W{1'b0}}, 1'b1};
  assign w_unused   = ^{w_exp_diff[EXP_W], w_exp_m1[EXP_W:LZC_W]};

  always_comb begin
    w_op        = '0;
    w_op.man    = in_man;
    w_op.sticky = in_sticky;
    w_op.zero   = w_zero;
    if (!w_zero) begin
      if (w_tiny) begin
        w_op.tiny = 1'b1;
        w_op.exp  = in_exp;
      end else if (w_gt) begin
        w_op.shift = w_lzc_c;
        w_op.exp   = w_exp_diff[EXP_W-1:0];
      end else begin
        // Only shift until the exponent reaches the subnormal floor.
        w_op.shift  = w_exp_m1[LZC_W-1:0];
        w_op.exp    = '0;
        w_op.denorm = 1'b1;
      end
    end
  end

  mul_norm_shl #(
    .MAN_W (MAN_W),
    .SH_W  (LZC_W)
  ) u_shl (
    .i_data  (r_s1.man),
    .i_shift (r_s1.shift),
    .o_data  (w_shl_man)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_man      <= '0;
      r_exp      <= '0;
      r_sticky   <= 1'b0;
      r_zero     <= 1'b0;
      r_denorm   <= 1'b0;
      r_tiny     <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_man    <= w_shl_man;
          r_exp    <= r_s1.exp;
          r_sticky <= r_s1.sticky;
          r_zero   <= r_s1.zero;
          r_denorm <= r_s1.denorm;
          r_tiny   <= r_s1.tiny;
        end
      end
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1 <= w_op;
        end
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_man    = r_man;
  assign out_exp    = r_exp;
  assign out_sticky = r_sticky;
  assign out_zero   = r_zero;
  assign out_denorm = r_denorm;
  assign out_tiny   = r_tiny;

endmodule
